mig_ui_model: RTL and testbench

Synthesizable responder for the MIG 7-series user (app_*) interface, the memory-controller end that the DRAM-access FSMs drive as initiator. It replaces the DDR3 controller in simulation and in DRAM-less builds. It stores 128-bit bursts in a small internal RAM, accepts write and read commands with MIG handshake semantics, and returns read data after a fixed latency. It models calibration delay and optional back-pressure so that initiator FSMs can be exercised in all handshake corners.

---
 rtl/mig_ui_model.sv | 117 +++++++++++
 tb/tb_mig_ui_model.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mig_ui_model.sv
// MIG 7-series app_* responder: RAM of 128-bit bursts, 1-entry write command/data buffers, reads return RD_LATENCY cycles after accept.
// app_rdy is low during calibration, while a write command waits for data, and in the periodic stall slot; app_wdf_rdy is low while data waits for its command.
module mig_ui_model #(
  parameter int MEM_DEPTH_LOG2 = 8,
  parameter int RD_LATENCY     = 4,
  parameter int CALIB_CYCLES   = 64,
  parameter int STALL_PERIOD   = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [28:0]  app_addr,
  input  logic [2:0]   app_cmd,
  input  logic         app_en,
  output logic         app_rdy,
  input  logic [127:0] app_wdf_data,
  input  logic [15:0]  app_wdf_mask,
  input  logic         app_wdf_wren,
  input  logic         app_wdf_end,
  output logic         app_wdf_rdy,
  output logic [127:0] app_rd_data,
  output logic         app_rd_data_valid,
  output logic         app_rd_data_end,
  output logic         init_calib_complete,
  output logic         err_cmd
);
  localparam int DEPTH = 2 ** MEM_DEPTH_LOG2;
  localparam int CW = $clog2(CALIB_CYCLES + 1);
  localparam int SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [CW-1:0] CALIB_LAST = (CALIB_CYCLES > 0) ? CW'(CALIB_CYCLES - 1) : '0;
  localparam logic [SW-1:0] STALL_LAST = (STALL_PERIOD > 0) ? SW'(STALL_PERIOD - 1) : '0;
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef logic [MEM_DEPTH_LOG2-1:0] idx_t;

  logic [127:0]          mem [DEPTH];
  logic [CW-1:0]         calib_cnt;
  logic [SW-1:0]         stall_cnt, stall_cnt_nxt;
  logic                  calib_nxt, stall_nxt;
  logic                  wc_vld, wc_vld_nxt, wd_vld, wd_vld_nxt;
  idx_t                  wc_idx, cmd_idx, commit_idx;
  logic [127:0]          wd_dat, commit_dat;
  logic [15:0]           wd_mask, commit_mask;
  logic                  cmd_acc, wc_new, rd_new, cmd_bad;
  logic                  wd_acc, wd_new, wd_bad, commit;
  logic [RD_LATENCY-1:0] pipe_vld;
  idx_t                  pipe_idx [RD_LATENCY];
  logic                  unused_addr;

  always_comb begin
    cmd_acc       = app_en && app_rdy;
    wc_new        = cmd_acc && (app_cmd == CMD_WR);
    rd_new        = cmd_acc && (app_cmd == CMD_RD);
    cmd_bad       = cmd_acc && !wc_new && !rd_new;
    wd_acc        = app_wdf_wren && app_wdf_rdy;
    wd_new        = wd_acc && app_wdf_end;
    wd_bad        = wd_acc && !app_wdf_end;
    cmd_idx       = app_addr[3 +: MEM_DEPTH_LOG2];
    // A buffered half always pairs with the newly arriving other half.
    commit_idx    = wc_vld ? wc_idx : cmd_idx;
    commit_dat    = wd_vld ? wd_dat : app_wdf_data;
    commit_mask   = wd_vld ? wd_mask : app_wdf_mask;
    commit        = (wc_vld || wc_new) && (wd_vld || wd_new);
    wc_vld_nxt    = (wc_vld || wc_new) && !commit;
    wd_vld_nxt    = (wd_vld || wd_new) && !commit;
    calib_nxt     = init_calib_complete || (calib_cnt == CALIB_LAST);
    stall_cnt_nxt = (stall_cnt == STALL_LAST) ? '0 : stall_cnt + 1'b1;
    stall_nxt     = (STALL_PERIOD != 0) && (stall_cnt_nxt == STALL_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      calib_cnt           <= '0;
      init_calib_complete <= 1'b0;
      stall_cnt           <= '0;
      app_rdy             <= 1'b0;
      app_wdf_rdy         <= 1'b0;
      wc_vld              <= 1'b0;
      wd_vld              <= 1'b0;
      pipe_vld            <= '0;
      err_cmd             <= 1'b0;
    end else begin
      if (calib_cnt != CALIB_LAST) calib_cnt <= calib_cnt + 1'b1;
      init_calib_complete <= calib_nxt;
      stall_cnt           <= stall_cnt_nxt;
      wc_vld              <= wc_vld_nxt;
      wd_vld              <= wd_vld_nxt;
      // Readies are registered from next-cycle state so they never depend on app_en/wren.
      app_rdy             <= calib_nxt && !wc_vld_nxt && !stall_nxt;
      app_wdf_rdy         <= calib_nxt && !wd_vld_nxt;
      pipe_vld[0]         <= rd_new;
      for (int i = 1; i < RD_LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
      if (cmd_bad || wd_bad) err_cmd <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wc_new) wc_idx <= cmd_idx;
    if (wd_new) begin
      wd_dat  <= app_wdf_data;
      wd_mask <= app_wdf_mask;
    end
    pipe_idx[0] <= cmd_idx;
    for (int i = 1; i < RD_LATENCY; i++) pipe_idx[i] <= pipe_idx[i-1];
    if (commit && !rst) begin
      for (int b = 0; b < 16; b++) begin
        if (!commit_mask[b]) mem[commit_idx][b*8 +: 8] <= commit_dat[b*8 +: 8];
      end
    end
  end

  // RAM is read as the read leaves the pipeline, so earlier commits are visible.
  assign app_rd_data_valid = pipe_vld[RD_LATENCY-1];
  assign app_rd_data_end   = app_rd_data_valid;
  assign app_rd_data       = app_rd_data_valid ? mem[pipe_idx[RD_LATENCY-1]] : '0;
  assign unused_addr       = ^{app_addr[28:3+MEM_DEPTH_LOG2], app_addr[2:0]};
endmodule

// File: tb/tb_mig_ui_model.sv
// Directed and randomized bench for mig_ui_model; a transaction-level model predicts every output each cycle.
module tb_mig_ui_model;
  localparam int AW  = 4;
  localparam int LAT = 4;
  localparam int CAL = 64;
  localparam int STL = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [28:0]  app_addr = '0;
  logic [2:0]   app_cmd = '0;
  logic         app_en = 1'b0;
  logic         app_rdy;
  logic [127:0] app_wdf_data = '0;
  logic [15:0]  app_wdf_mask = '0;
  logic         app_wdf_wren = 1'b0;
  logic         app_wdf_end = 1'b1;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic         init_calib_complete;
  logic         err_cmd;

  always #5 clk = ~clk;

  mig_ui_model #(.MEM_DEPTH_LOG2(AW), .RD_LATENCY(LAT), .CALIB_CYCLES(CAL), .STALL_PERIOD(STL)) dut (
    .clk(clk), .rst(rst), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_rdy(app_rdy), .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end), .init_calib_complete(init_calib_complete), .err_cmd(err_cmd)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (tick %0d)", tag, got, exp, tick);
    end
  endtask

  // Reference model: edges since reset release, pending write halves, RAM image, reads due by tick.
  typedef struct {int due; logic [AW-1:0] idx;} rd_t;
  logic [127:0]  mem_m [2**AW];
  int            cyc = 0;
  int            tick = 0;
  bit            wc_p = 0, wd_p = 0, err_m = 0;
  logic [AW-1:0] wc_i = '0;
  logic [127:0]  wd_d = '0;
  logic [15:0]   wd_m = '0;
  rd_t           rq[$];
  bit            acc_c, acc_w;

  function automatic bit m_calib();
    return cyc >= CAL;
  endfunction
  function automatic bit m_stall();
    return (STL != 0) && ((cyc % STL) == STL - 1);
  endfunction
  function automatic bit m_rdy();
    return m_calib() && !wc_p && !m_stall();
  endfunction
  function automatic bit m_wrdy();
    return m_calib() && !wd_p;
  endfunction

  task automatic step();
    bit rdy_e, wrdy_e, exp_v;
    logic [127:0] exp_d;
    rd_t r;
    rdy_e = m_rdy();
    wrdy_e = m_wrdy();
    acc_c = !rst && app_en && rdy_e;
    acc_w = !rst && app_wdf_wren && wrdy_e;
    if (rst) begin
      cyc = 0; wc_p = 0; wd_p = 0; err_m = 0;
      rq.delete();
    end else begin
      if (acc_c) begin
        if (app_cmd == 3'b000) begin
          wc_p = 1; wc_i = app_addr[3 +: AW];
        end else if (app_cmd == 3'b001) begin
          r.due = tick + LAT; r.idx = app_addr[3 +: AW];
          rq.push_back(r);
        end else err_m = 1;
      end
      if (acc_w) begin
        if (app_wdf_end) begin
          wd_p = 1; wd_d = app_wdf_data; wd_m = app_wdf_mask;
        end else err_m = 1;
      end
      if (wc_p && wd_p) begin
        for (int b = 0; b < 16; b++)
          if (!wd_m[b]) mem_m[wc_i][b*8 +: 8] = wd_d[b*8 +: 8];
        wc_p = 0; wd_p = 0;
      end
      cyc++;
    end
    @(posedge clk);
    #1;
    tick++;
    exp_v = 0;
    exp_d = '0;
    if (rq.size() > 0 && rq[0].due == tick) begin
      exp_v = 1;
      exp_d = mem_m[rq[0].idx];
      r = rq.pop_front();
    end
    chk("calib", init_calib_complete, m_calib());
    chk("app_rdy", app_rdy, m_rdy());
    chk("app_wdf_rdy", app_wdf_rdy, m_wrdy());
    chk("err_cmd", err_cmd, err_m);
    chk("rd_valid", app_rd_data_valid, exp_v);
    chk("rd_end", app_rd_data_end, exp_v);
    chk("rd_data", app_rd_data, exp_d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive_idle();
    app_en = 1'b0;
    app_wdf_wren = 1'b0;
    app_wdf_end = 1'b1;
  endtask

  task automatic sync_rdy();
    int n;
    n = 0;
    while (!(m_rdy() && m_wrdy()) && n < 10) begin step(); n++; end
  endtask

  task automatic wait_calib(input string tag);
    int n;
    n = 0;
    while (!init_calib_complete && n < 200) begin step(); n++; end
    chk(tag, n, CAL);
  endtask

  task automatic wr(input logic [28:0] a, input logic [127:0] d, input logic [15:0] m,
                    input int cmd_dly, input int dat_dly);
    bit cdone, ddone;
    int n;
    cdone = 0; ddone = 0; n = 0;
    app_cmd = 3'b000; app_addr = a; app_wdf_data = d; app_wdf_mask = m; app_wdf_end = 1'b1;
    while (!(cdone && ddone) && n < 100) begin
      app_en = !cdone && (n >= cmd_dly);
      app_wdf_wren = !ddone && (n >= dat_dly);
      step();
      n++;
      if (acc_c) cdone = 1;
      if (acc_w) ddone = 1;
      if (cdone && !ddone) chk("wc_holds_rdy_low", app_rdy, 1'b0);
    end
    drive_idle();
    chk("wr_done", cdone && ddone, 1'b1);
  endtask

  task automatic rd_issue(input logic [28:0] a, output int t_acc);
    int n, t0;
    n = 0; t_acc = -1;
    app_cmd = 3'b001; app_addr = a; app_en = 1'b1;
    while (t_acc < 0 && n < 50) begin
      t0 = tick;
      step();
      n++;
      if (acc_c) t_acc = t0;
    end
    app_en = 1'b0;
    chk("rd_accepted", t_acc >= 0, 1'b1);
  endtask

  task automatic rd_chk(input string tag, input logic [28:0] a, input logic [127:0] exp);
    int t_acc, n;
    rd_issue(a, t_acc);
    n = 0;
    while (!app_rd_data_valid && n < 20) begin step(); n++; end
    chk($sformatf("%s_latency", tag), tick - t_acc, LAT);
    chk($sformatf("%s_data", tag), app_rd_data, exp);
    chk($sformatf("%s_end", tag), app_rd_data_end, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] d1, d2, d3, old8, exp_mask;
    int k, nv, n, t_acc;
    bit got;
    d1 = 128'haabbccdd_eeff0011_22334455_66778899;
    d2 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    d3 = 128'h5a5a_a5a5_0f0f_f0f0_1234_5678_9abc_def0;
    drive_idle();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    wait_calib("calib_rise_cycles");

    for (int i = 0; i < 2**AW; i++)
      wr(29'(i * 8), {$urandom, $urandom, $urandom, $urandom}, 16'h0, 0, 0);

    wr(29'h10, d1, 16'h0, 2, 0);
    rd_chk("data_first", 29'h10, d1);
    wr(29'h20, d2, 16'h0, 0, 5);
    rd_chk("cmd_first", 29'h20, d2);

    old8 = mem_m[1];
    exp_mask = {{12{8'h11}}, old8[31:0]};
    sync_rdy();
    wr(29'h8, {16{8'h11}}, 16'h000F, 0, 0);
    rd_chk("mask", 29'h8, exp_mask);

    k = 0; nv = 0; n = 0;
    app_cmd = 3'b001;
    while ((k < 4 || nv < 4) && n < 60) begin
      app_en = (k < 4);
      app_addr = 29'(k * 8);
      step();
      n++;
      if (acc_c) k++;
      if (app_rd_data_valid) begin
        if (nv < 4) chk($sformatf("b2b_data_%0d", nv), app_rd_data, mem_m[nv]);
        nv++;
      end
    end
    drive_idle();
    chk("b2b_count", nv, 4);

    sync_rdy();
    app_cmd = 3'b010; app_addr = 29'h8; app_en = 1'b1;
    got = 0; n = 0;
    while (!got && n < 50) begin step(); n++; if (acc_c) got = 1; end
    drive_idle();
    chk("illegal_accepted", got, 1'b1);
    chk("illegal_err", err_cmd, 1'b1);
    rd_chk("illegal_ram", 29'h8, exp_mask);

    rd_issue(29'h10, t_acc);
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_drops_read", app_rd_data_valid, 1'b0);
    end
    chk("rst_err_clear", err_cmd, 1'b0);
    chk("rst_calib_low", init_calib_complete, 1'b0);
    rst = 1'b0;
    wait_calib("recalib_cycles");

    app_wdf_data = ~d3; app_wdf_end = 1'b0; app_wdf_wren = 1'b1;
    got = 0; n = 0;
    while (!got && n < 20) begin step(); n++; if (acc_w) got = 1; end
    drive_idle();
    chk("no_end_err", err_cmd, 1'b1);
    wr(29'h30, d3, 16'h0, 0, 3);
    rd_chk("no_end_discarded", 29'h30, d3);

    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(15, 0);
      app_en = ($urandom_range(2, 0) != 0);
      app_cmd = (r < 7) ? 3'b000 : (r < 15) ? 3'b001 : 3'($urandom_range(7, 2));
      app_addr = 29'($urandom);
      app_wdf_wren = ($urandom_range(1, 0) == 1);
      app_wdf_end = ($urandom_range(19, 0) != 0);
      app_wdf_data = {$urandom, $urandom, $urandom, $urandom};
      app_wdf_mask = ($urandom_range(3, 0) == 0) ? 16'($urandom) : 16'h0;
      rst = ($urandom_range(399, 0) == 0);
      step();
    end
    rst = 1'b0;
    drive_idle();
    idle(80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
